load_use_hazard_unit: RTL and testbench

- Issue-side interlock that complements the EX/MEM and MEM/WB forwarding path. It covers the hazards that forwarding cannot resolve.
- Tracks the destination registers of the instructions in flight in a 3-entry shadow pipeline (EX, MEM, WB).
- Compares the ID-stage source registers against those entries. On a hazard it stalls PC and IF/ID and injects a bubble into ID/EX.
- Sits beside the decode stage. Its outputs drive the PC enable, the IF/ID enable and the ID/EX control-zeroing mux.

---
 rtl/load_use_hazard_unit_if.sv | 37 +++
 rtl/load_use_hazard_unit.sv | 105 ++++++++++
 tb/tb_load_use_hazard_unit.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_use_hazard_unit_if.sv
// Decode-side bus of the load-use hazard unit.
// The decode stage (master) drives the ID-stage instruction fields and flush.
// The hazard unit (slave) returns the stall, the pipeline enables and the stall counter.
interface load_use_hazard_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  // ID-stage instruction and flush
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  flush;

  // interlock outputs
  logic                  stall;
  logic                  pc_write;
  logic                  if_id_write;
  logic                  id_ex_bubble;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_mem_read, flush,
    input  stall, pc_write, if_id_write, id_ex_bubble, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_mem_read, flush,
    output stall, pc_write, if_id_write, id_ex_bubble, stall_count
  );
endinterface

// File: rtl/load_use_hazard_unit.sv
// Issue-side load-use interlock.
// - Keeps a 3-deep shadow of the destination registers in flight (EX, MEM, WB).
// - Stalls PC and IF/ID, and bubbles ID/EX, when an ID source register
//   cannot be satisfied by forwarding.
// Build option HAZARD_NO_FORWARD_EN:
// - Defined: cores without forwarding; any in-flight producer blocks a reader.
// - Undefined (default): only a load directly ahead in EX blocks a reader.
module load_use_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    arst,
  load_use_hazard_unit_if.slave   bus
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  is_load;
  } entry_t;

  entry_t           ex_q, mem_q, wb_q;
  entry_t           ex_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic hit_ex, hit_mem, hit_wb;
  logic raw, stall, issue;

  // An entry blocks a source only when it is live and the source is not x0.
  function automatic logic match(input entry_t e, input logic [REG_ADDR_W-1:0] r);
    return e.valid && (e.rd == r) && (r != '0);
  endfunction

  function automatic logic hit(input entry_t e,
                               input logic u1, input logic [REG_ADDR_W-1:0] r1,
                               input logic u2, input logic [REG_ADDR_W-1:0] r2);
    return (u1 && match(e, r1)) || (u2 && match(e, r2));
  endfunction

  // Hazard detection and next EX shadow entry; purely combinational on the
  // shadow state so a stall is seen in the same cycle the dependent sits in ID.
  always_comb begin
    hit_ex  = hit(ex_q,  bus.id_use_rs1, bus.id_rs1, bus.id_use_rs2, bus.id_rs2);
    hit_mem = hit(mem_q, bus.id_use_rs1, bus.id_rs1, bus.id_use_rs2, bus.id_rs2);
    hit_wb  = hit(wb_q,  bus.id_use_rs1, bus.id_rs1, bus.id_use_rs2, bus.id_rs2);
`ifdef HAZARD_NO_FORWARD_EN
    // no bypass network: WB is included because the register file is not
    // write-through
    raw     = hit_ex || hit_mem || hit_wb;
`else
    // EX/MEM and MEM/WB forwarding covers everything except a load in EX
    raw     = hit_ex && ex_q.is_load;
`endif
    // flush wins: the squashed ID instruction does not need to be held
    stall   = bus.id_valid && !bus.flush && raw;
    issue   = bus.id_valid && !stall && !bus.flush &&
              bus.id_reg_write && (bus.id_rd != '0);

    ex_d = '0;
    if (issue) begin
      ex_d.valid   = 1'b1;
      ex_d.rd      = bus.id_rd;
      ex_d.is_load = bus.id_mem_read;
    end
  end

  // Saturating stall-cycle counter next state.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Shadow pipeline advances every cycle; identical in both builds.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  // Performance counter register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall        = stall;
  assign bus.pc_write     = !stall;
  assign bus.if_id_write  = !stall;
  assign bus.id_ex_bubble = stall || bus.flush;
  assign bus.stall_count  = stall_cnt_q;

  // is_load of the older entries is tracked but only EX's is consulted;
  // mem/wb hits only matter in the no-forward build.
  logic unused_bits;
  assign unused_bits = ^{mem_q.is_load, wb_q.is_load, hit_mem, hit_wb};

endmodule

// File: tb/tb_load_use_hazard_unit.sv
// Self-checking bench for load_use_hazard_unit: directed scenarios plus a
// randomized run against a history-based reference model.
module tb_load_use_hazard_unit;
  localparam int RW   = 5;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  load_use_hazard_unit_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus();
  load_use_hazard_unit #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk (clk),
    .arst(arst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: history of the last three issue slots, newest first.
  bit m_v[3];
  int m_rd[3];
  bit m_ld[3];
  int m_cnt;

  function automatic bit m_hit(int k);
    bit h1, h2;
    if (!m_v[k]) return 1'b0;
    h1 = bus.id_use_rs1 && (int'(bus.id_rs1) != 0) && (int'(bus.id_rs1) == m_rd[k]);
    h2 = bus.id_use_rs2 && (int'(bus.id_rs2) != 0) && (int'(bus.id_rs2) == m_rd[k]);
    return h1 || h2;
  endfunction

  function automatic bit m_stall();
    bit raw;
`ifdef HAZARD_NO_FORWARD_EN
    raw = m_hit(0) || m_hit(1) || m_hit(2);
`else
    raw = m_hit(0) && m_ld[0];
`endif
    return bus.id_valid && !bus.flush && raw;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 3; k++) begin
      m_v[k] = 1'b0; m_rd[k] = 0; m_ld[k] = 1'b0;
    end
    m_cnt = 0;
  endtask

  // Advance model with the current inputs, then cross the clock edge.
  task automatic adv();
    bit st, iss;
    st  = m_stall();
    iss = bus.id_valid && !st && !bus.flush && bus.id_reg_write && (int'(bus.id_rd) != 0);
    for (int k = 2; k > 0; k--) begin
      m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_ld[k] = m_ld[k-1];
    end
    m_v[0]  = iss;
    m_rd[0] = iss ? int'(bus.id_rd) : 0;
    m_ld[0] = iss && bus.id_mem_read;
    if (st && m_cnt < CMAX) m_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit rw, bit mr, bit fl);
    bus.id_valid     = v;
    bus.id_rs1       = RW'(rs1);
    bus.id_use_rs1   = u1;
    bus.id_rs2       = RW'(rs2);
    bus.id_use_rs2   = u2;
    bus.id_rd        = RW'(rd);
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.flush        = fl;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      adv();
    end
  endtask

  task automatic pulse_reset();
    arst = 1'b1;
    #1;
    m_reset();
    @(posedge clk);
    #1;
    arst = 1'b0;
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 0, 0, 5, 1, 1, 0);   // lw x5,0(x1)
    #4; adv();
    drive(1, 5, 1, 7, 1, 6, 1, 0, 0);   // add x6,x5,x7
    #4;
    n_vec++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL reset_prestall: got %b want 1", bus.stall); end
    arst = 1'b1;
    #1;
    n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
    n_vec++; if (bus.pc_write !== 1'b1) begin n_err++; $display("FAIL reset_pc_write: got %b want 1", bus.pc_write); end
    n_vec++; if (bus.if_id_write !== 1'b1) begin n_err++; $display("FAIL reset_if_id_write: got %b want 1", bus.if_id_write); end
    n_vec++; if (bus.id_ex_bubble !== 1'b0) begin n_err++; $display("FAIL reset_bubble: got %b want 0", bus.id_ex_bubble); end
    n_vec++; if (bus.stall_count !== CW'(0)) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.stall_count); end
    m_reset();
    @(posedge clk); #1;
    arst = 1'b0;
    drive(1, 1, 1, 2, 1, 3, 1, 0, 0);   // add x3,x1,x2
    #4;
    n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL reset_add_nostall: got %b want 0", bus.stall); end
    adv();
  endtask

  task automatic test_load_use();
    idle(3);
    drive(1, 1, 1, 0, 0, 5, 1, 1, 0);   // lw x5,0(x1)
    #4; adv();
    drive(1, 5, 1, 7, 1, 6, 1, 0, 0);   // add x6,x5,x7
    #4;
    n_vec++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %b want 1", bus.stall); end
    n_vec++; if (bus.id_ex_bubble !== 1'b1) begin n_err++; $display("FAIL lu_bubble: got %b want 1", bus.id_ex_bubble); end
    n_vec++; if (bus.pc_write !== 1'b0) begin n_err++; $display("FAIL lu_pc_write: got %b want 0", bus.pc_write); end
    adv();
    #4;
    n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL lu_release: got %b want 0", bus.stall); end
    n_vec++; if (bus.stall_count !== CW'(1)) begin n_err++; $display("FAIL lu_count: got %0d want 1", bus.stall_count); end
    adv();
  endtask

  task automatic test_no_false_hazard();
    idle(3);
    drive(1, 1, 1, 0, 0, 0, 1, 1, 0);   // lw x0,0(x1)
    #4; adv();
    drive(1, 0, 1, 0, 1, 0, 0, 0, 0);   // reader of x0
    #4;
    n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL nf_x0: got %b want 0", bus.stall); end
    adv();
    drive(1, 1, 1, 0, 0, 5, 1, 1, 0);   // lw x5,0(x1)
    #4; adv();
    drive(1, 1, 1, 5, 0, 0, 0, 0, 0);   // rs2=5 but not read
    #4;
    n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL nf_unused_rs2: got %b want 0", bus.stall); end
    adv();
`ifndef HAZARD_NO_FORWARD_EN
    idle(3);
    drive(1, 1, 1, 2, 1, 5, 1, 0, 0);   // add x5,x1,x2
    #4; adv();
    drive(1, 5, 1, 0, 0, 9, 1, 0, 0);   // reader of x5
    #4;
    n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL nf_alu_dep: got %b want 0", bus.stall); end
    adv();
`endif
  endtask

  task automatic test_flush();
    int cnt0;
    idle(3);
    drive(1, 1, 1, 0, 0, 5, 1, 1, 0);   // lw x5
    #4; adv();
    cnt0 = m_cnt;
    drive(1, 5, 1, 7, 1, 6, 1, 0, 1);   // dependent with flush
    #4;
    n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL fl_stall: got %b want 0", bus.stall); end
    n_vec++; if (bus.id_ex_bubble !== 1'b1) begin n_err++; $display("FAIL fl_bubble: got %b want 1", bus.id_ex_bubble); end
    adv();
    n_vec++; if (bus.stall_count !== CW'(cnt0)) begin n_err++; $display("FAIL fl_count: got %0d want %0d", bus.stall_count, cnt0); end
    drive(1, 5, 1, 7, 1, 6, 1, 0, 0);   // same dependent, EX now a bubble
    #4;
    n_vec++; if (bus.stall !== m_stall()) begin n_err++; $display("FAIL fl_ex_bubble: got %b want %b", bus.stall, m_stall()); end
    adv();
  endtask

  task automatic test_saturation();
    bit s;
    pulse_reset();
    for (int p = 0; p < 20; p++) begin
      drive(1, 1, 1, 0, 0, 5, 1, 1, 0);
      #4; adv();
      drive(1, 5, 1, 7, 1, 6, 1, 0, 0);
      for (int g = 0; g < 8; g++) begin
        #4;
        s = m_stall();
        n_vec++;
        if (bus.stall !== s || bus.stall_count !== CW'(m_cnt)) begin
          n_err++;
          $display("FAIL sat_step: got stall=%b cnt=%0d want stall=%b cnt=%0d", bus.stall, bus.stall_count, s, m_cnt);
        end
        adv();
        if (!s) break;
      end
    end
    n_vec++; if (bus.stall_count !== CW'(CMAX)) begin n_err++; $display("FAIL sat_final: got %0d want %0d", bus.stall_count, CMAX); end
  endtask

`ifdef HAZARD_NO_FORWARD_EN
  task automatic test_no_forward();
    int n;
    pulse_reset();
    drive(1, 1, 1, 2, 1, 4, 1, 0, 0);   // add x4,x1,x2
    #4; adv();
    drive(1, 4, 1, 9, 1, 8, 1, 0, 0);   // sub x8,x4,x9
    n = 0;
    for (int g = 0; g < 8; g++) begin
      #4;
      if (bus.stall !== 1'b1) break;
      n++; adv();
    end
    adv();
    n_vec++; if (n !== 3) begin n_err++; $display("FAIL nofwd_adjacent: got %0d stalls want 3", n); end
    idle(3);
    drive(1, 1, 1, 2, 1, 4, 1, 0, 0);   // add x4
    #4; adv();
    drive(1, 1, 1, 2, 1, 10, 1, 0, 0);  // independent
    #4; adv();
    drive(1, 4, 1, 0, 0, 11, 1, 0, 0);  // reader of x4
    n = 0;
    for (int g = 0; g < 8; g++) begin
      #4;
      if (bus.stall !== 1'b1) break;
      n++; adv();
    end
    adv();
    n_vec++; if (n !== 2) begin n_err++; $display("FAIL nofwd_one_gap: got %0d stalls want 2", n); end
  endtask
`endif

  task automatic test_random();
    bit held, exp;
    pulse_reset();
    held = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!held)
        drive($urandom_range(0, 3) != 0,
              int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)), 1'b0);
      bus.flush = ($urandom_range(0, 7) == 0);
      #4;
      exp = m_stall();
      n_vec++;
      if ({bus.stall, bus.pc_write, bus.if_id_write, bus.id_ex_bubble} !==
          {exp, !exp, !exp, exp || bus.flush}) begin
        n_err++;
        $display("FAIL rnd_ctrl c=%0d: got %b%b%b%b want %b%b%b%b", c,
                 bus.stall, bus.pc_write, bus.if_id_write, bus.id_ex_bubble,
                 exp, !exp, !exp, exp || bus.flush);
      end
      n_vec++;
      if (bus.stall_count !== CW'(m_cnt)) begin
        n_err++; $display("FAIL rnd_count c=%0d: got %0d want %0d", c, bus.stall_count, m_cnt);
      end
      if ($urandom_range(0, 199) == 0) begin
        arst = 1'b1;
        #1;
        n_vec++;
        if (bus.stall !== 1'b0 || bus.stall_count !== CW'(0)) begin
          n_err++; $display("FAIL rnd_arst c=%0d: got stall=%b cnt=%0d want 0/0", c, bus.stall, bus.stall_count);
        end
        m_reset();
        @(posedge clk); #1;
        arst = 1'b0;
        held = 1'b0;
      end else begin
        held = exp;
        adv();
      end
    end
  endtask

  initial begin
    arst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    arst = 1'b0;
    test_reset();
    test_load_use();
    test_no_false_hazard();
    test_flush();
    test_saturation();
`ifdef HAZARD_NO_FORWARD_EN
    test_no_forward();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
